// File: rtl/tmul_row_sequencer.sv
// Issue side of the FP16 TMUL FMA array: skews A rows into the array, tracks rows in flight,
// and returns product rows through a result FIFO whose free space is reserved at issue time.
module tmul_row_sequencer #(
    parameter int N_K        = 16,
    parameter int N_COLS     = 32,
    parameter int EW         = 16,
    parameter int LAT        = 15,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [N_K*EW-1:0]        a_row,
    input  logic                     a_last,
    output logic [N_K*EW-1:0]        arr_rowa,
    input  logic [N_COLS*EW-1:0]     arr_rowprod,
    output logic                     b_lock,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [N_COLS*EW-1:0]     res_data,
    output logic                     res_last,
    output logic [$clog2(LAT+2)-1:0] inflight
);
    localparam int INF_W = $clog2(LAT + 2);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int SUM_W = CNT_W + 1;
    localparam int RES_W = N_COLS * EW;

    localparam logic [SUM_W-1:0] CREDITS   = SUM_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL      = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [INF_W-1:0] INF_MAX   = INF_W'(LAT + 1);

    logic             accept;
    logic             capture;
    logic             cap_last;
    logic             pop;
    logic [SUM_W-1:0] credit_used;

    logic [LAT-1:0]   tag_vld_q;
    logic [LAT-1:0]   tag_last_q;
    logic [INF_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] fifo_count_q, fifo_count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    logic [RES_W-1:0] mem_data [FIFO_DEPTH];
    logic             mem_last [FIFO_DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    // Every result slot is claimed at issue, so a_ready only looks at registered counts.
    assign credit_used = SUM_W'(fifo_count_q) + SUM_W'(inflight_q);
    assign a_ready     = !rst && (credit_used < CREDITS);
    assign accept      = a_valid && a_ready;

    assign capture  = tag_vld_q[LAT-1];
    assign cap_last = tag_last_q[LAT-1];
    assign pop      = res_valid && res_ready;

    assign b_lock    = (inflight_q != '0) || accept;
    assign inflight  = inflight_q;
    assign res_valid = (fifo_count_q != '0);
    assign res_data  = mem_data[rd_ptr_q];
    assign res_last  = mem_last[rd_ptr_q];

    // Element 0 enters stage 0 in the issue cycle; element k is delayed by a k-deep shift.
    assign arr_rowa[EW-1:0] = accept ? a_row[EW-1:0] : '0;

    for (genvar k = 1; k < N_K; k++) begin : g_skew
        logic [EW-1:0] sr_q [k];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s < k; s++) sr_q[s] <= '0;
            end else begin
                sr_q[0] <= accept ? a_row[k*EW +: EW] : '0;
                for (int s = 1; s < k; s++) sr_q[s] <= sr_q[s-1];
            end
        end

        assign arr_rowa[k*EW +: EW] = sr_q[k-1];
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        inflight_d   = inflight_q;
        fifo_count_d = fifo_count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;

        unique case ({accept, capture})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase

        unique case ({capture, pop})
            2'b10:   fifo_count_d = fifo_count_q + 1'b1;
            2'b01:   fifo_count_d = fifo_count_q - 1'b1;
            default: fifo_count_d = fifo_count_q;
        endcase

        if (capture) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)     rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use <= so each one samples pre-edge values regardless of statement order.
        if (rst) begin
            tag_vld_q    <= '0;
            tag_last_q   <= '0;
            inflight_q   <= '0;
            fifo_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            tag_vld_q    <= {tag_vld_q[LAT-2:0], accept};
            tag_last_q   <= {tag_last_q[LAT-2:0], accept && a_last};
            inflight_q   <= inflight_d;
            fifo_count_q <= fifo_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // NOTE: result storage is not reset; fifo_count_q gates every read, so stale slots are never observed.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem_data[wr_ptr_q] <= arr_rowprod;
            mem_last[wr_ptr_q] <= cap_last;
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(capture && !pop && fifo_count_q == FULL));

    inflight_in_range: assert property (@(posedge clk) disable iff (rst)
        inflight_q <= INF_MAX);

endmodule

// File: tb/tb_tmul_row_sequencer.sv
// Scoreboard bench for tmul_row_sequencer: an FP16 integer-valued array model drives arr_rowprod
// from the skewed A stream; expected rows come from the unskewed A row times B.
module tb_tmul_row_sequencer;
    localparam int N_K        = 16;
    localparam int N_COLS     = 32;
    localparam int EW         = 16;
    localparam int LAT        = 15;
    localparam int FIFO_DEPTH = 32;
    localparam int ROW_W      = N_K * EW;
    localparam int RES_W      = N_COLS * EW;
    localparam int INF_W      = $clog2(LAT + 2);

    logic               clk;
    logic               rst;
    logic               a_valid;
    logic               a_ready;
    logic [ROW_W-1:0]   a_row;
    logic               a_last;
    logic [ROW_W-1:0]   arr_rowa;
    logic [RES_W-1:0]   arr_rowprod;
    logic               b_lock;
    logic               res_valid;
    logic               res_ready;
    logic [RES_W-1:0]   res_data;
    logic               res_last;
    logic [INF_W-1:0]   inflight;

    typedef struct {
        logic [RES_W-1:0] data;
        logic             last;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    int               b_mat [N_K][N_COLS];
    logic [ROW_W-1:0] hist [N_K];

    tmul_row_sequencer #(
        .N_K(N_K), .N_COLS(N_COLS), .EW(EW), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_row(a_row), .a_last(a_last),
        .arr_rowa(arr_rowa), .arr_rowprod(arr_rowprod), .b_lock(b_lock),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
        .inflight(inflight)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Values are kept to small integers, which FP16 represents exactly.
    function automatic int fp16_to_int(input logic [15:0] h);
        int e;
        int m;
        if (h[14:0] == 15'd0) return 0;
        e = int'(h[14:10]) - 15;
        m = int'({1'b1, h[9:0]});
        if (e < 0) return 0;
        if (e > 20) return 1 << 20;
        if (e >= 10) return m << (e - 10);
        return m >> (10 - e);
    endfunction

    function automatic logic [15:0] int_to_fp16(input int n);
        int e;
        int m;
        if (n <= 0) return 16'h0000;
        e = 0;
        while ((n >> (e + 1)) != 0) e++;
        m = (e <= 10) ? (n << (10 - e)) : (n >> (e - 10));
        return {1'b0, 5'(e + 15), m[9:0]};
    endfunction

    function automatic logic [RES_W-1:0] ref_product(input logic [ROW_W-1:0] row);
        logic [RES_W-1:0] r;
        int s;
        r = '0;
        for (int j = 0; j < N_COLS; j++) begin
            s = 0;
            for (int k = 0; k < N_K; k++) s += fp16_to_int(row[k*EW +: EW]) * b_mat[k][j];
            r[j*EW +: EW] = int_to_fp16(s);
        end
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] rand_row();
        logic [ROW_W-1:0] r;
        for (int k = 0; k < N_K; k++) r[k*EW +: EW] = int_to_fp16(int'($urandom_range(8)));
        return r;
    endfunction

    task automatic check(input string name, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, RES_W'(act), RES_W'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic [ROW_W-1:0] row, input logic last);
        bit done;
        done    = 1'b0;
        a_valid = 1'b1;
        a_row   = row;
        a_last  = last;
        for (int g = 0; g < 200 && !done; g++) begin
            @(negedge clk);
            done = a_ready;
            tick();
        end
        a_valid = 1'b0;
        check1("send_accepted", done, 1'b1);
    endtask

    // Counts cycles from the accept cycle to the first cycle with res_valid.
    task automatic wait_res(output int n);
        n = 1;
        while (n < 64) begin
            @(negedge clk);
            if (res_valid) break;
            tick();
            n++;
        end
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        res_ready = 1'b1;
        while (sb.size() != 0 && g < 400) begin
            tick();
            g++;
        end
        check(name, RES_W'(sb.size()), '0);
    endtask

    // FMA array model: stage k sees arr_rowa[k] from LAT-k cycles ago; product is the sum over stages.
    initial begin
        logic [RES_W-1:0] prod;
        int s;
        for (int i = 0; i < N_K; i++) hist[i] = '0;
        arr_rowprod = '0;
        forever begin
            @(negedge clk);
            for (int i = N_K - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = arr_rowa;
            for (int j = 0; j < N_COLS; j++) begin
                s = 0;
                for (int k = 0; k < N_K; k++)
                    s += fp16_to_int(hist[LAT-k][k*EW +: EW]) * b_mat[k][j];
                prod[j*EW +: EW] = int_to_fp16(s);
            end
            arr_rowprod = prod;
        end
    end

    // Issue monitor: every accepted row pushes its expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (a_valid && a_ready) begin
                e.data = ref_product(a_row);
                e.last = a_last;
                sb.push_back(e);
            end
        end
    end

    // Result monitor: every handshake pops and compares in acceptance order.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    check1("res_unexpected", res_valid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("res_data", res_data, e.data);
                    check1("res_last", res_last, e.last);
                end
            end
        end
    end

    initial begin
        int n;
        int acc;
        bit took;
        rst       = 1'b1;
        a_valid   = 1'b0;
        a_row     = '0;
        a_last    = 1'b0;
        res_ready = 1'b0;
        for (int k = 0; k < N_K; k++)
            for (int j = 0; j < N_COLS; j++) b_mat[k][j] = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check1("rst_a_ready", a_ready, 1'b1);
        check1("rst_res_valid", res_valid, 1'b0);
        check1("rst_b_lock", b_lock, 1'b0);
        check("rst_arr_rowa", RES_W'(arr_rowa), '0);
        check("rst_inflight", RES_W'(inflight), '0);
        tick();

        // Single row of 1.0 with B all 1.0 sums to 16.0 in every lane.
        res_ready = 1'b1;
        send_row({N_K{16'h3C00}}, 1'b1);
        wait_res(n);
        check("t1_latency", RES_W'(n), RES_W'(16));
        check("t1_lanes", res_data, {N_COLS{16'h4C00}});
        check1("t1_last", res_last, 1'b1);
        tick();

        // Back-to-back rows: gap-free results, b_lock held until the last capture.
        for (int d = 0; d < 34; d++) begin
            a_valid = (d < 16);
            a_last  = (d == 15);
            for (int k = 0; k < N_K; k++) a_row[k*EW +: EW] = int_to_fp16(d + 1);
            @(negedge clk);
            if (d < 16) check1("t2_accept", a_ready, 1'b1);
            check1("t2_res_valid", res_valid, (d >= 16 && d <= 31));
            check1("t2_b_lock", b_lock, (d <= 30));
            tick();
        end
        a_valid = 1'b0;

        // Bubbles: results keep the issue spacing.
        for (int d = 0; d < 50; d++) begin
            a_valid = (d < 32) && (d % 2 == 0);
            a_last  = (d == 30);
            a_row   = rand_row();
            @(negedge clk);
            if (a_valid) check1("t4_accept", a_ready, 1'b1);
            check1("t4_res_valid", res_valid, (d >= 16 && d < 48 && ((d - 16) % 2 == 0)));
            tick();
        end
        a_valid = 1'b0;

        // Reset with 7 rows in flight and 3 in the FIFO.
        res_ready = 1'b0;
        for (int d = 0; d < 19; d++) begin
            a_valid = (d < 10);
            a_last  = (d == 9);
            a_row   = rand_row();
            if (d == 18) begin
                rst = 1'b1;
                sb.delete();
            end
            @(negedge clk);
            if (d < 10) check1("t5_accept", a_ready, 1'b1);
            if (d == 18) begin
                check("t5_inflight_before", RES_W'(inflight), RES_W'(7));
                check1("t5_fifo_before", res_valid, 1'b1);
            end
            tick();
        end
        rst     = 1'b0;
        a_valid = 1'b0;
        @(negedge clk);
        check1("t5_res_valid", res_valid, 1'b0);
        check("t5_inflight", RES_W'(inflight), '0);
        check1("t5_b_lock", b_lock, 1'b0);
        check1("t5_a_ready", a_ready, 1'b1);
        check("t5_arr_rowa", RES_W'(arr_rowa), '0);
        tick();
        res_ready = 1'b1;
        send_row(rand_row(), 1'b1);
        wait_res(n);
        check("t5_latency", RES_W'(n), RES_W'(16));
        tick();
        repeat (30) tick();
        @(negedge clk);
        check1("t5_no_stale", res_valid, 1'b0);
        tick();

        // Back-pressure: exactly FIFO_DEPTH rows accepted, then a_ready drops.
        res_ready = 1'b0;
        acc       = 0;
        a_valid   = 1'b1;
        a_row     = rand_row();
        a_last    = 1'($urandom_range(1));
        for (int d = 0; d < 60; d++) begin
            @(negedge clk);
            took = a_ready;
            if (took) acc++;
            tick();
            if (took) begin
                a_row  = rand_row();
                a_last = 1'($urandom_range(1));
            end
        end
        check("t3_accepted", RES_W'(acc), RES_W'(FIFO_DEPTH));
        @(negedge clk);
        check1("t3_a_ready_low", a_ready, 1'b0);
        check("t3_inflight", RES_W'(inflight), '0);
        tick();
        a_valid = 1'b0;

        // One pop frees one credit; the refilled row lands while the FIFO pops again.
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        a_valid   = 1'b1;
        a_row     = rand_row();
        a_last    = 1'b1;
        @(negedge clk);
        check1("t6_reopen", a_ready, 1'b1);
        tick();
        a_valid = 1'b0;
        for (int d = 0; d < 14; d++) begin
            @(negedge clk);
            check1("t6_credit_hold", a_ready, 1'b0);
            tick();
        end
        res_ready = 1'b1;
        @(negedge clk);
        check1("t6_capture_cycle", a_ready, 1'b0);
        tick();
        res_ready = 1'b0;
        @(negedge clk);
        check1("t6_count_kept", a_ready, 1'b1);
        check1("t6_res_valid", res_valid, 1'b1);
        tick();
        drain("t6_drain");

        // Random traffic with a random B tile.
        repeat (4) tick();
        for (int k = 0; k < N_K; k++)
            for (int j = 0; j < N_COLS; j++) b_mat[k][j] = int'($urandom_range(2));
        a_row  = rand_row();
        a_last = 1'($urandom_range(1));
        for (int d = 0; d < 500; d++) begin
            a_valid   = ($urandom_range(99) < 70);
            res_ready = ($urandom_range(99) < 60);
            @(negedge clk);
            took = a_valid && a_ready;
            tick();
            if (took) begin
                a_row  = rand_row();
                a_last = 1'($urandom_range(1));
            end
        end
        a_valid = 1'b0;
        drain("t7_drain");
        repeat (2) tick();
        @(negedge clk);
        check1("end_res_valid", res_valid, 1'b0);
        check("end_inflight", RES_W'(inflight), '0);
        check1("end_b_lock", b_lock, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
